debounce_scheduler: RTL
=======================

# debounce_scheduler

Time-multiplexed debouncer for up to N_CH slide switches. A single prescaler and one shared compare/update path service every channel in a round-robin scan, instead of one wide counter per switch. The block sits between the board switch pins and the control logic. It delivers stable switch levels plus one-cycle rise/fall pulses, so downstream FSMs need no edge detectors of their own.

## Interface
- Simulacion, 0, 1 selects the short simulation sample period
- N_CH, 16, number of switch channels, range 1..16
- CLK_HZ, 16_000_000, clock frequency in Hz
- DEBOUNCE_MS_HW, 10, debounce window in hardware mode, in ms
- STABLE_SAMPLES, 4, consecutive mismatching samples required to accept a change, minimum 2
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high; all state cleared at the next posedge
- SW  in  N_CH  raw asynchronous switch inputs
- enable  in  1  permits scan ticks
- sw_db  out  N_CH  debounced levels
- rise  out  N_CH  one-cycle pulse per channel on a debounced 0→1 change
- fall  out  N_CH  one-cycle pulse per channel on a debounced 1→0 change
- busy  out  1  high while a scan is in progress (SCAN state)
- scan_done  out  1  one-cycle pulse in the cycle after the last channel is processed

## Operation
- **Synchronizer:** a two-flop synchronizer per channel, reset to 0. It produces sync[N_CH-1:0].
- **Tick period:** TICK_CYC = Simulacion ? N_CH+2 : (CLK_HZ/1000)*DEBOUNCE_MS_HW/STABLE_SAMPLES.
  - Elaboration fails ($error) if TICK_CYC < N_CH+2.
- **Prescaler:** counts 0..TICK_CYC-1 and wraps to 0.
  - tick = enable && (prescaler == TICK_CYC-1).
  - While enable=0 the prescaler is held at 0.
- **Channel counters:** cnt[i] per channel, width max(1, $clog2(STABLE_SAMPLES)), reset 0.
- **FSM states and transitions:**
  - IDLE: on tick go to SCAN with idx=0.
  - SCAN: process channel idx each cycle. At idx == N_CH-1 go to DONE; otherwise idx++.
  - DONE: assert scan_done, then go to IDLE.
- **Processing channel i:**
  - If sync[i] == sw_db[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_SAMPLES-1: sw_db[i] <= sync[i], cnt[i] <= 0, and rise[i] or fall[i] <= 1 according to the new level.
  - Else: cnt[i] <= cnt[i]+1.
- **Pulses:** rise and fall are registered. Every bit not being set in the current cycle is cleared, so each pulse is exactly one cycle wide.
- **enable deasserted mid-scan:** the current scan completes, including DONE. No further scans start.
- **Reset:** reset during any state returns the FSM to IDLE and clears idx, all cnt, the prescaler and the synchronizers.
- **Reset values:** sw_db=0, rise=0, fall=0, busy=0, scan_done=0.

## Timing
- SW to sync latency: 2 cycles.
- Channel i is processed in SCAN cycle i, where cycle 0 is the cycle after tick.
- Its sw_db/rise/fall update is visible one cycle later.
- Pulses of different channels updated in the same scan are offset by their index difference in cycles.
- Acceptance latency: a change must be seen by STABLE_SAMPLES consecutive scans.
  - Worst case is about (STABLE_SAMPLES+1)*TICK_CYC + N_CH + 3 cycles from the SW edge.
- Any scan in which the input agrees with sw_db restarts the count.
- busy is high for exactly N_CH cycles per scan. scan_done follows the last busy cycle.
- The TICK_CYC bound guarantees that no tick occurs outside IDLE.

## Test plan
All scenarios use Simulacion=1, N_CH=4, STABLE_SAMPLES=2, which gives TICK_CYC=6.
1. **Reset:** assert reset for 3 cycles with SW=4'hF → sw_db, rise, fall, busy and scan_done all 0 at the first posedge and throughout reset.
2. **Single rise:** enable=1, SW[2] 0→1 and held → sw_db[2]=1 after the second scan that sees the mismatch; rise[2] high exactly 1 cycle; fall=0; other sw_db bits stay 0.
3. **Glitch rejection:** SW[1] high for 3 cycles between ticks → at most one scan sees it; cnt[1] is cleared on the next scan; sw_db[1] stays 0; no rise pulse.
4. **Simultaneous rise:** SW[0] and SW[3] rise in the same cycle → both accepted in the same scan; rise[0] and rise[3] pulses are exactly 3 cycles apart.
5. **Release:** after scenario 2, drop SW[2] to 0 → fall[2] one-cycle pulse and sw_db[2]=0, two scans later.
6. **enable and mid-scan reset:**
   - Drop enable during SCAN → scan_done still pulses, then busy stays 0 and sw_db stays frozen despite SW changes.
   - Re-enable, then pulse reset mid-scan → all outputs 0 at the next posedge; FSM in IDLE.

Source files
------------

// File: rtl/debounce_scheduler_if.sv
// Switch-side and control-side signals of the debounce scheduler.
// master drives raw switches and enable; slave is the debouncer itself.
interface debounce_scheduler_if #(
  parameter int N_CH = 16
);
  logic [N_CH-1:0] SW;
  logic            enable;
  logic [N_CH-1:0] sw_db;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            busy;
  logic            scan_done;

  modport master (
    output SW, enable,
    input  sw_db, rise, fall, busy, scan_done
  );

  modport slave (
    input  SW, enable,
    output sw_db, rise, fall, busy, scan_done
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Round-robin switch debouncer: one prescaler and one shared compare/update path
// service every channel in turn, producing stable levels and one-cycle edge pulses.
module debounce_scheduler #(
  parameter int Simulacion     = 0,
  parameter int N_CH           = 16,
  parameter int CLK_HZ         = 16_000_000,
  parameter int DEBOUNCE_MS_HW = 10,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  debounce_scheduler_if.slave sw_if
);

  localparam int TICK_CYC = (Simulacion != 0) ? N_CH + 2
                          : (CLK_HZ / 1000) * DEBOUNCE_MS_HW / STABLE_SAMPLES;
  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int CW = ($clog2(STABLE_SAMPLES) > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_SAMPLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_CH - 1);

  // A full scan plus DONE must fit between ticks, so a tick never lands outside IDLE.
  generate
    if (TICK_CYC < N_CH + 2) begin : g_bad_tick
      $error("debounce_scheduler: TICK_CYC too small for N_CH");
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("debounce_scheduler: N_CH out of range 1..16");
    end
    if (STABLE_SAMPLES < 2) begin : g_bad_ss
      $error("debounce_scheduler: STABLE_SAMPLES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] sw_db_q, sw_db_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;

  always_comb begin
    sync1_d = sw_if.SW;
    sync2_d = sync1_q;

    tick = sw_if.enable && (presc_q == PRESC_MAX);
    if (!sw_if.enable || presc_q == PRESC_MAX) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sw_db_d = sw_db_q;
    rise_d  = '0;
    fall_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // Shared update path: only channel idx_q is examined this cycle.
        if (sync2_q[idx_q] == sw_db_q[idx_q]) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] == CNT_MAX) begin
          cnt_d[idx_q]   = '0;
          sw_db_d[idx_q] = sync2_q[idx_q];
          rise_d[idx_q]  = sync2_q[idx_q];
          fall_d[idx_q]  = ~sync2_q[idx_q];
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '{default: '0};
      sw_db_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      sw_db_q <= sw_db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sw_if.sw_db     = sw_db_q;
  assign sw_if.rise      = rise_q;
  assign sw_if.fall      = fall_q;
  assign sw_if.busy      = busy_q;
  assign sw_if.scan_done = done_q;

endmodule
